fifo_mac_seq: RTL and testbench
===============================

# fifo_mac_seq

Sequencer for the operand-FIFO pair that feeds the MAC datapath. It accepts a start command and fills two FIFO instances (A and B) in lockstep from an upstream valid/ready stream, DEPTH words each. It then drains both FIFOs in lockstep into the MAC and issues MAC clear/enable strobes aligned to the FIFO read data. It sits between the upstream data source, the two FIFO instances and the MAC unit, and it owns every FIFO `wren`/`rden`.

## Interface
- `DEPTH`, default 8: FIFO depth and the number of words per operation. Must be ≥ 2.
- `DATA_WIDTH`, default 8: operand width.
- `clk`, in, 1: the single clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset. Shared with both FIFOs.
- `start`, in, 1: begin an operation. Sampled only in IDLE.
- `in_valid`, in, 1: upstream operand pair is valid.
- `in_a`, `in_b`, in, DATA_WIDTH: upstream operands.
- `in_ready`, out, 1: the sequencer accepts an operand pair this cycle.
- `wren_a`, `wren_b`, out, 1: FIFO write enables. Always equal to each other.
- `wdata_a`, `wdata_b`, out, DATA_WIDTH: FIFO write data, a combinational pass-through of `in_a`/`in_b`.
- `full_a`, `full_b`, `empty_a`, `empty_b`, in, 1: FIFO status flags.
- `rden`, out, 1: read enable, driven to both FIFOs.
- `mac_clr`, out, 1: one-cycle accumulator clear pulse.
- `mac_en`, out, 1: MAC accumulate enable. Registered.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle completion pulse. Registered.
- `err`, out, 1: sticky flag for a FIFO-pair mismatch.

## Operation
- States: IDLE, FILL, DRAIN, FLUSH, DONE.
- IDLE
  - `start`=1 → FILL.
  - `mac_clr`=1 in the same cycle.
  - Clears `wcnt`, `rcnt` and `err`.
- FILL
  - `in_ready` = (`wcnt` < DEPTH) & !`full_a` & !`full_b`.
  - `wren_a` = `wren_b` = `in_valid` & `in_ready`.
  - Each write increments `wcnt`.
  - On the write that makes `wcnt` = DEPTH → DRAIN.
- DRAIN
  - `rden` = (`rcnt` < DEPTH) & !`empty_a` & !`empty_b`.
  - Each read increments `rcnt`.
  - On the read that makes `rcnt` = DEPTH → FLUSH.
- FLUSH: one cycle, so the last `mac_en` completes → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `mac_en` is `rden` delayed by one register. FIFO `o_data` is valid the cycle after `rden`, so `mac_en` lines up with the read data.
- `err` is set if `empty_a` ≠ `empty_b` or `full_a` ≠ `full_b` while in FILL or DRAIN. It holds until the next accepted `start`. The sequence continues when `err` is set.
- `in_ready`, `wren`, `rden` are 0 in every state other than the one that owns them.
- `start` while `busy` is ignored.

## Timing
- Reset values: state IDLE. `wcnt`=`rcnt`=0. All outputs 0 (`in_ready`, `wren_*`, `rden`, `mac_clr`, `mac_en`, `busy`, `done`, `err`).
- Reset mid-operation returns to IDLE immediately. The FIFOs share `rst_n` and empty at the same time; there is no partial resume.
- Counters are $clog2(DEPTH+1) bits wide and never wrap. The `< DEPTH` guards stop writes and reads at exactly DEPTH.
- Best-case latency, with `in_valid` held high:
  - `start` edge N → first `wren` in cycle N+1.
  - Last write in cycle N+DEPTH.
  - First `rden` in cycle N+DEPTH+1.
  - Last `mac_en` in cycle N+2·DEPTH+1 (the FLUSH cycle).
  - `done` in cycle N+2·DEPTH+2.
- Upstream stall: `in_valid`=0 inserts a bubble and `wcnt` holds.
- FIFO full in FILL (not normally reachable, since DEPTH matches): `in_ready`=0 and the sequencer waits.
- FIFO empty in DRAIN: `rden`=0 and the sequencer waits. `mac_en` follows a cycle later with the same gaps.

## Structure
- Package `fifo_mac_pkg` holds:
  - `typedef enum logic [2:0] {IDLE, FILL, DRAIN, FLUSH, DONE} seq_state_t`
  - default `DEPTH`/`DATA_WIDTH` localparams.
- Single module with no sub-modules.
- The two counters are inline `always_ff` blocks.
- The state register is `always_ff` with async reset. Next-state and strobe logic is one `always_comb`.

## Test plan
- **Nominal:** reset; `start`=1 for 1 cycle; `in_valid`=1 with `in_a`=1..8 and `in_b`=2..9.
  - Expect exactly 8 `wren` cycles, then 8 `rden` cycles.
  - `mac_en` is high for 8 cycles, each one cycle after the matching `rden`.
  - `done` pulses 18 cycles after `start`. `busy` falls with it.
- **Upstream stall:** drop `in_valid` for 3 cycles after the 4th write.
  - Expect `wcnt` to hold at 4, and no `wren` during the gap.
  - `done` is delayed by exactly 3 cycles.
- **Reset mid-DRAIN:** pull `rst_n` low after the 3rd `rden`.
  - Expect all outputs 0 asynchronously, and state IDLE.
  - A subsequent `start` runs a full 8/8 sequence.
- **Start while busy:** pulse `start` during FILL. Expect no effect on counts or timing.
- **Flag mismatch:** force `empty_b`=1 with `empty_a`=0 during DRAIN.
  - Expect `rden`=0 and `err`=1, held through DONE.
  - `err` clears on the next `start`.
- **Back-to-back operations:** assert `start` in the cycle after `done`.
  - Expect `mac_clr` to pulse, the counters restart from 0, and a second `done` after 18 more cycles.

Source files
------------

// File: rtl/fifo_mac_pkg.sv
// fifo_mac_pkg: state encoding and default sizes for the MAC operand-FIFO sequencer
package fifo_mac_pkg;
  typedef enum logic [2:0] {IDLE, FILL, DRAIN, FLUSH, DONE} seq_state_t;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/fifo_mac_seq.sv
// fifo_mac_seq: fills FIFO pair A/B in lockstep, drains them into the MAC with aligned clr/en strobes
module fifo_mac_seq
  import fifo_mac_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  in_ready,
  output logic                  wren_a,
  output logic                  wren_b,
  output logic [DATA_WIDTH-1:0] wdata_a,
  output logic [DATA_WIDTH-1:0] wdata_b,
  input  logic                  full_a,
  input  logic                  full_b,
  input  logic                  empty_a,
  input  logic                  empty_b,
  output logic                  rden,
  output logic                  mac_clr,
  output logic                  mac_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int CW = $clog2(DEPTH + 1);
  seq_state_t state, state_nx;
  logic [CW-1:0] wcnt, rcnt;
  logic wr, mism;
  assign wren_a = wr;
  assign wren_b = wr;
  assign wdata_a = in_a;
  assign wdata_b = in_b;
  always_comb begin
    in_ready = state == FILL && wcnt < CW'(DEPTH) && !full_a && !full_b;
    wr = in_valid && in_ready;
    rden = state == DRAIN && rcnt < CW'(DEPTH) && !empty_a && !empty_b;
    mac_clr = state == IDLE && start;
    busy = state != IDLE;
    mism = (state == FILL || state == DRAIN) && (empty_a != empty_b || full_a != full_b);
    state_nx = mac_clr ? FILL :
               (wr && wcnt == CW'(DEPTH - 1)) ? DRAIN :
               (rden && rcnt == CW'(DEPTH - 1)) ? FLUSH :
               state == FLUSH ? DONE :
               state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wcnt <= '0;
    else if (state == IDLE) wcnt <= '0;
    else if (wr) wcnt <= wcnt + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rcnt <= '0;
    else if (state == IDLE) rcnt <= '0;
    else if (rden) rcnt <= rcnt + 1'b1;
  // mac_en trails rden by one cycle so it coincides with FIFO read data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mac_en <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      mac_en <= rden;
      done <= state == FLUSH;
      err <= mac_clr ? 1'b0 : err | mism;
    end
endmodule

// File: tb/tb_fifo_mac_seq.sv
// tb_fifo_mac_seq: directed scoreboard bench with a counting model of the FIFO pair
module tb_fifo_mac_seq;
  import fifo_mac_pkg::*;
  localparam int D = 8;
  localparam int DW = 8;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [DW-1:0] in_a = 0, in_b = 0, wdata_a, wdata_b;
  logic in_ready, wren_a, wren_b, rden, mac_clr, mac_en, busy, done, err;
  logic full_a, full_b, empty_a, empty_b, force_eb = 0, rden_d = 0;
  int ca, cb, cyc = 0, t0 = 0, nw = 0, nr = 0, nm = 0, n_cmp = 0, n_err = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] p;

  fifo_mac_seq #(.DEPTH(D), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_ready(in_ready), .wren_a(wren_a), .wren_b(wren_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .full_a(full_a), .full_b(full_b), .empty_a(empty_a), .empty_b(empty_b), .rden(rden),
    .mac_clr(mac_clr), .mac_en(mac_en), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ca <= 0;
      cb <= 0;
    end else begin
      ca <= ca + int'(wren_a) - int'(rden);
      cb <= cb + int'(wren_b) - int'(rden);
    end
  assign empty_a = ca == 0;
  assign empty_b = cb == 0 || force_eb;
  assign full_a = ca == D;
  assign full_b = cb == D;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      if (wren_a || wren_b) begin
        nw++;
        check("wren_pair", 32'({wren_a, wren_b}), 32'b11);
        if (exp_q.size() == 0) check("wren_unexpected", exp_q.size(), 1);
        else begin
          p = exp_q.pop_front();
          check("wdata", 32'({wdata_a, wdata_b}), 32'(p));
        end
      end
      check("mac_en_align", mac_en, rden_d);
      if (rden) nr++;
      if (mac_en) nm++;
      rden_d = rden;
    end else rden_d = 0;

  task automatic start_op();
    start = 1;
    t0 = cyc + 1;
    nw = 0;
    nr = 0;
    nm = 0;
    #1;
    check("mac_clr", mac_clr, 1);
    check("busy_idle_pre", busy, 0);
  endtask

  task automatic feed(input int stall_at, input int stall_len, input bit poke);
    int w = 0, st = 0, g = 0, pushed = -1;
    @(posedge clk); #1;
    start = 0;
    check("err_clr", err, 0);
    check("wcnt_restart", dut.wcnt, 0);
    check("rcnt_restart", dut.rcnt, 0);
    while (w < D && g < 100) begin
      g++;
      start = poke && w == 2;
      if (w == stall_at && st < stall_len) begin
        in_valid = 0;
        st++;
      end else begin
        in_valid = 1;
        in_a = DW'(w + 1);
        in_b = DW'(w + 2);
        if (pushed != w) begin
          exp_q.push_back({in_a, in_b});
          pushed = w;
        end
      end
      @(negedge clk);
      if (!in_valid) begin
        check("stall_wren", wren_a, 0);
        check("stall_wcnt", dut.wcnt, stall_at);
      end
      if (wren_a && w == 0 && stall_at != 0) check("first_wren_lat", cyc + 1 - t0, 1);
      if (wren_a) w++;
      @(posedge clk); #1;
    end
    in_valid = 0;
    start = 0;
    check("feed_count", w, D);
  endtask

  task automatic wait_done(input int lat, input bit exp_err);
    int g = 0;
    @(negedge clk);
    while (!done && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("done_lat", cyc + 1 - t0, lat);
    check("busy_at_done", busy, 1);
    check("err_at_done", err, 32'(exp_err));
    check("n_wren", nw, D);
    check("n_rden", nr, D);
    check("n_mac_en", nm, D);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
  endtask

  task automatic wait_reads(input int n);
    int g = 0;
    while (nr < n && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("reads_reached", nr, n);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", 32'({in_ready, wren_a, wren_b, rden, mac_clr, mac_en, busy, done, err}), 0);
    check("rst_state", dut.state, IDLE);
    rst_n = 1;
    @(posedge clk); #1;
    start_op(); feed(-1, 0, 0); wait_done(18, 0);
    start_op(); feed(4, 3, 0); wait_done(21, 0);
    start_op(); feed(-1, 0, 1); wait_done(18, 0);
    start_op(); feed(-1, 0, 0);
    wait_reads(2);
    force_eb = 1;
    repeat (3) begin
      @(negedge clk);
      check("mism_rden", rden, 0);
      @(posedge clk); #1;
      check("mism_err", err, 1);
    end
    force_eb = 0;
    wait_done(21, 1);
    check("err_held_idle", err, 1);
    start_op(); feed(-1, 0, 0); wait_done(18, 0);
    start_op(); feed(-1, 0, 0);
    wait_reads(3);
    rst_n = 0;
    #1;
    check("midrst_outs", 32'({in_ready, wren_a, wren_b, rden, mac_clr, mac_en, busy, done, err}), 0);
    check("midrst_state", dut.state, IDLE);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    start_op(); feed(-1, 0, 0); wait_done(18, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
